// File: rtl/ahb_master_req_ctrl_if.sv
// Command and AHB address-phase bundle between one master's local logic, its
// requester and the per-slave arbiters.
//   master modport : the requester (ahb_master_req_ctrl)
//   slave  modport : the other side (local command source + arbiters/slaves)
//   cmd_*          : command handshake and transfer description
//   hreq/hgrant    : one bit per slave arbiter
//   hwait          : inverse HREADY of the selected slave
//   htrans/haddr/hburst/hwrite : address phase; done/err : completion pulses
interface ahb_master_req_ctrl_if #(
  parameter int unsigned SLAVE_NUM = 6,
  parameter int unsigned ADDR_W    = 32
);
  localparam int unsigned SLV_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_W-1:0]    cmd_addr;
  logic                 cmd_write;
  logic [2:0]           cmd_burst;
  logic [SLV_W-1:0]     cmd_slave;
  logic [SLAVE_NUM-1:0] hreq;
  logic [SLAVE_NUM-1:0] hgrant;
  logic                 hwait;
  logic [1:0]           htrans;
  logic [ADDR_W-1:0]    haddr;
  logic [2:0]           hburst;
  logic                 hwrite;
  logic                 done;
  logic                 err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_slave, hgrant, hwait,
    output cmd_ready, hreq, htrans, haddr, hburst, hwrite, done, err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_slave, hgrant, hwait,
    input  cmd_ready, hreq, htrans, haddr, hburst, hwrite, done, err
  );
endinterface

// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB requester. Accepts one transfer command, requests the target
// slave's arbiter, waits for its grant, then issues the burst address phase beat
// by beat. A grant that never arrives aborts with an err pulse.
//   hclk, hreset_n : clock, asynchronous active-low reset
//   bus (master)   : command handshake, hreq/hgrant per slave, hwait,
//                    registered address phase outputs, done/err pulses
module ahb_master_req_ctrl #(
  parameter int unsigned SLAVE_NUM = 6,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic                   hclk,
  input logic                   hreset_n,
  ahb_master_req_ctrl_if.master bus
);
  localparam int unsigned SLV_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  localparam logic [SLV_W:0]    SLV_LIMIT = (SLV_W + 1)'(SLAVE_NUM);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  typedef enum logic [1:0] {StIdle, StReq, StAddr, StData} state_e;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_beats = 5'd4;
      3'd4, 3'd5: burst_beats = 5'd8;
      3'd6, 3'd7: burst_beats = 5'd16;
      default:    burst_beats = 5'd1;  // SINGLE, and INCR issues one beat
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [SLAVE_NUM-1:0] hreq_q, hreq_d;
  logic [1:0]           htrans_q, htrans_d;
  logic [ADDR_W-1:0]    haddr_q, haddr_d;
  logic [2:0]           hburst_q, hburst_d;
  logic                 hwrite_q, hwrite_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [4:0]           beats_q, beats_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SLV_W-1:0]     slave_q, slave_d;

  // WRAP bursts are the even, non-SINGLE encodings; only the low bits inside the
  // beats*bytes block advance, the upper bits stay put.
  logic              is_wrap;
  logic [ADDR_W-1:0] wrap_mask, addr_inc, next_addr;

  assign is_wrap   = (hburst_q[0] == 1'b0) && (hburst_q != HBURST_SINGLE);
  assign wrap_mask = (ADDR_W'(burst_beats(hburst_q)) * ADDR_STEP) - ADDR_W'(1);
  assign addr_inc  = haddr_q + ADDR_STEP;
  assign next_addr = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;

  always_comb begin
    state_d  = state_q;
    hreq_d   = hreq_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hburst_d = hburst_q;
    hwrite_d = hwrite_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmo_d    = tmo_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    slave_d  = slave_q;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          hwrite_d = bus.cmd_write;
          hburst_d = bus.cmd_burst;
          slave_d  = bus.cmd_slave;
          beats_d  = burst_beats(bus.cmd_burst);
          if ({1'b0, bus.cmd_slave} < SLV_LIMIT) begin
            state_d = StReq;
            hreq_d  = SLAVE_NUM'(1) << bus.cmd_slave;
          end else begin
            // No arbiter behind this index: consume the command and flag it.
            err_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (bus.hgrant[slave_q]) begin
          state_d  = StAddr;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = addr_q;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = StIdle;
          hreq_d  = '0;
          err_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      StAddr: begin
        if (!bus.hwait) begin
          if (beats_q == 5'd1) begin
            state_d  = StData;
            hreq_d   = '0;
            htrans_d = HTRANS_IDLE;
          end else begin
            haddr_d  = next_addr;
            htrans_d = HTRANS_SEQ;
            beats_d  = beats_q - 5'd1;
          end
        end
      end
      StData: begin
        if (!bus.hwait) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q  <= StIdle;
      hreq_q   <= '0;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hburst_q <= HBURST_SINGLE;
      hwrite_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      beats_q  <= '0;
      addr_q   <= '0;
      slave_q  <= '0;
    end else begin
      state_q  <= state_d;
      hreq_q   <= hreq_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hburst_q <= hburst_d;
      hwrite_q <= hwrite_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      slave_q  <= slave_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.hreq      = hreq_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hburst    = hburst_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
